id_ex_stage: RTL and testbench

//  ID/EX pipeline register sitting directly downstream of the register file. Captures

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use stall insertion and flush.
// Data1/Data2 come straight from the register file, which only commits on the clock edge.
module id_ex_stage #(
   parameter int CTRL_W   = 8,
   parameter int LOAD_LAT = 1
) (
   input  logic              clkIn,
   input  logic              resetIn,
   input  logic              validIn,
   input  logic [31:0]       pcIn,
   input  logic [4:0]        rs1In,
   input  logic [4:0]        rs2In,
   input  logic              useRs1In,
   input  logic              useRs2In,
   input  logic [4:0]        rdIn,
   input  logic [31:0]       immIn,
   input  logic              regWriteIn,
   input  logic              memReadIn,
   input  logic [CTRL_W-1:0] ctrlIn,
   input  logic [31:0]       Data1In,
   input  logic [31:0]       Data2In,
   input  logic [4:0]        wbRdIn,
   input  logic [31:0]       wbDataIn,
   input  logic              wbWriteIn,
   input  logic              flushIn,
   output logic              stallOut,
   output logic              validOut,
   output logic [31:0]       pcOut,
   output logic [31:0]       immOut,
   output logic [31:0]       Data1Out,
   output logic [31:0]       Data2Out,
   output logic [4:0]        rs1Out,
   output logic [4:0]        rs2Out,
   output logic [4:0]        rdOut,
   output logic              regWriteOut,
   output logic              memReadOut,
   output logic [CTRL_W-1:0] ctrlOut
);

   typedef enum logic {IDLE, STALL} state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              valid_q, reg_write_q, mem_read_q;
   logic [31:0]       pc_q, imm_q, data1_q, data2_q;
   logic [4:0]        rs1_q, rs2_q, rd_q;
   logic [CTRL_W-1:0] ctrl_q;

   logic        hazard;
   logic        latch;
   logic [31:0] d1, d2;

   // The register file writes on the same edge we capture, so forward the write-back value.
   assign d1 = (wbWriteIn && (wbRdIn == rs1In)) ? wbDataIn : Data1In;
   assign d2 = (wbWriteIn && (wbRdIn == rs2In)) ? wbDataIn : Data2In;

   assign hazard = validIn & valid_q & mem_read_q & ~flushIn &
                   ((useRs1In & (rd_q == rs1In)) | (useRs2In & (rd_q == rs2In)));

   assign stallOut = ((state_q == IDLE) & hazard) | ((state_q == STALL) & ~flushIn);

   // Anything that is not a clean capture of a real instruction enters EX as an all-zero bubble.
   assign latch = (state_q == IDLE) & ~flushIn & ~hazard & validIn;

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         valid_q     <= 1'b0;
         pc_q        <= '0;
         imm_q       <= '0;
         data1_q     <= '0;
         data2_q     <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         ctrl_q      <= '0;
      end else begin
         valid_q     <= latch;
         pc_q        <= latch ? pcIn       : '0;
         imm_q       <= latch ? immIn      : '0;
         data1_q     <= latch ? d1         : '0;
         data2_q     <= latch ? d2         : '0;
         rs1_q       <= latch ? rs1In      : '0;
         rs2_q       <= latch ? rs2In      : '0;
         rd_q        <= latch ? rdIn       : '0;
         reg_write_q <= latch ? regWriteIn : 1'b0;
         mem_read_q  <= latch ? memReadIn  : 1'b0;
         ctrl_q      <= latch ? ctrlIn     : '0;

         case (state_q)
            IDLE: begin
               if (hazard) begin
                  cnt_q <= 4'(LOAD_LAT - 1);
                  if (LOAD_LAT > 1)
                     state_q <= STALL;
               end
            end
            STALL: begin
               if (flushIn) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1)
                     state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign validOut    = valid_q;
   assign pcOut       = pc_q;
   assign immOut      = imm_q;
   assign Data1Out    = data1_q;
   assign Data2Out    = data2_q;
   assign rs1Out      = rs1_q;
   assign rs2Out      = rs2_q;
   assign rdOut       = rd_q;
   assign regWriteOut = reg_write_q;
   assign memReadOut  = mem_read_q;
   assign ctrlOut     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised scoreboard bench for id_ex_stage; two instances with LOAD_LAT=1 and LOAD_LAT=3.
// The reference model tracks architectural register values and counts stall cycles per instruction.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2;
      logic        use1, use2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        rw, mr;
      logic [7:0]  ctrl;
      logic        wbw;
      logic [4:0]  wbrd;
      logic [31:0] wbdata;
      logic [3:0]  flush_at;
   } instr_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, imm, d1, d2;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mr;
      logic [7:0]  ctrl;
   } ex_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [159:0] a, input logic [159:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                 input logic u2, input logic [4:0] rd, input logic mr);
      instr_t t;
      t = '0;
      t.valid = 1'b1; t.pc = 32'h1000 + 32'(rd) * 4; t.imm = 32'h40 + 32'(rs1);
      t.rs1 = rs1; t.rs2 = rs2; t.use1 = u1; t.use2 = u2; t.rd = rd;
      t.rw = 1'b1; t.mr = mr; t.ctrl = 8'hA5; t.flush_at = 4'hF;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      t.valid = ($urandom_range(0, 7) != 0);
      t.pc = $urandom; t.imm = $urandom; t.ctrl = 8'($urandom);
      t.rs1 = 5'($urandom_range(0, 7)); t.rs2 = 5'($urandom_range(0, 7));
      t.rd = 5'($urandom_range(0, 7));
      t.use1 = 1'($urandom); t.use2 = 1'($urandom); t.rw = 1'($urandom);
      t.mr = ($urandom_range(0, 2) == 0);
      t.wbw = 1'b0; t.wbrd = '0; t.wbdata = '0;
      t.flush_at = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 3)) : 4'hF;
      return t;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;

      logic        resetIn, validIn, useRs1In, useRs2In, regWriteIn, memReadIn;
      logic        wbWriteIn, flushIn, stallOut, validOut, regWriteOut, memReadOut;
      logic [31:0] pcIn, immIn, Data1In, Data2In, wbDataIn;
      logic [31:0] pcOut, immOut, Data1Out, Data2Out;
      logic [4:0]  rs1In, rs2In, rdIn, wbRdIn, rs1Out, rs2Out, rdOut;
      logic [7:0]  ctrlIn, ctrlOut;

      id_ex_stage #(.CTRL_W(8), .LOAD_LAT(LAT)) u_dut (
         .clkIn(clk), .resetIn(resetIn), .validIn(validIn), .pcIn(pcIn),
         .rs1In(rs1In), .rs2In(rs2In), .useRs1In(useRs1In), .useRs2In(useRs2In),
         .rdIn(rdIn), .immIn(immIn), .regWriteIn(regWriteIn), .memReadIn(memReadIn),
         .ctrlIn(ctrlIn), .Data1In(Data1In), .Data2In(Data2In), .wbRdIn(wbRdIn),
         .wbDataIn(wbDataIn), .wbWriteIn(wbWriteIn), .flushIn(flushIn),
         .stallOut(stallOut), .validOut(validOut), .pcOut(pcOut), .immOut(immOut),
         .Data1Out(Data1Out), .Data2Out(Data2Out), .rs1Out(rs1Out), .rs2Out(rs2Out),
         .rdOut(rdOut), .regWriteOut(regWriteOut), .memReadOut(memReadOut),
         .ctrlOut(ctrlOut)
      );

      ex_t act;
      assign act = ex_t'({validOut, pcOut, immOut, Data1Out, Data2Out, rs1Out, rs2Out,
                          rdOut, regWriteOut, memReadOut, ctrlOut});

      logic        mon_en = 1'b0;
      logic        done   = 1'b0;
      ex_t         ex_q[$];
      logic        stall_q[$];
      logic [31:0] rf[32];
      ex_t         ex_last;
      int          stall_rem;

      task automatic set_inputs(input instr_t t);
         validIn = t.valid; pcIn = t.pc; rs1In = t.rs1; rs2In = t.rs2;
         useRs1In = t.use1; useRs2In = t.use2; rdIn = t.rd; immIn = t.imm;
         regWriteIn = t.rw; memReadIn = t.mr; ctrlIn = t.ctrl;
         Data1In = rf[t.rs1]; Data2In = rf[t.rs2];
         wbWriteIn = 1'b0; wbRdIn = '0; wbDataIn = '0; flushIn = 1'b0;
      endtask

      // One cycle of reference model: registers read after this edge's write, stall counted per instruction.
      task automatic drive_cycle(input instr_t t, input logic flush, output logic advance);
         ex_t e;
         logic exp_stall, haz;
         @(negedge clk); #1;
         set_inputs(t);
         wbWriteIn = t.wbw; wbRdIn = t.wbrd; wbDataIn = t.wbdata; flushIn = flush;
         if (t.wbw) rf[t.wbrd] = t.wbdata;
         haz = !flush && t.valid && ex_last.valid && ex_last.mr &&
               ((t.use1 && ex_last.rd == t.rs1) || (t.use2 && ex_last.rd == t.rs2));
         e = '0;
         advance = 1'b0;
         if (stall_rem > 0) begin
            exp_stall = !flush;
            advance   = flush;
            stall_rem = flush ? 0 : stall_rem - 1;
         end else if (flush) begin
            exp_stall = 1'b0;
            advance   = 1'b1;
         end else if (haz) begin
            exp_stall = 1'b1;
            stall_rem = LAT - 1;
         end else begin
            exp_stall = 1'b0;
            advance   = 1'b1;
            if (t.valid)
               e = '{valid: 1'b1, pc: t.pc, imm: t.imm, d1: rf[t.rs1], d2: rf[t.rs2],
                     rs1: t.rs1, rs2: t.rs2, rd: t.rd, rw: t.rw, mr: t.mr, ctrl: t.ctrl};
         end
         ex_last = e;
         stall_q.push_back(exp_stall);
         ex_q.push_back(e);
      endtask

      initial begin : monitor
         forever begin
            @(negedge clk); #2;
            if (mon_en && stall_q.size() > 0)
               check($sformatf("lat%0d_stall", LAT), 160'(stallOut), 160'(stall_q.pop_front()));
            @(posedge clk); #1;
            if (mon_en && ex_q.size() > 0)
               check($sformatf("lat%0d_ex", LAT), 160'(act), 160'(ex_q.pop_front()));
         end
      end

      initial begin : driver
         instr_t prog[$];
         instr_t t;
         logic   adv;
         int     pres;
         for (int i = 0; i < 32; i++) rf[i] = $urandom;
         rf[3] = 32'd31; rf[5] = 32'h1234; rf[6] = 32'h5555;

         // Reset with every input held high
         resetIn = 1'b0;
         t = '1;
         set_inputs(t);
         wbWriteIn = 1'b1; wbRdIn = '1; wbDataIn = '1; flushIn = 1'b1;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check($sformatf("lat%0d_reset_regs", LAT), 160'(act), 160'(0));
         check($sformatf("lat%0d_reset_stall", LAT), 160'(stallOut), 160'(0));
         t = '0;
         set_inputs(t);
         #1 resetIn = 1'b1;
         ex_last = '0; stall_rem = 0;
         mon_en = 1'b1;

         prog.push_back(mk(5'd3, 5'd4, 1'b1, 1'b1, 5'd1, 1'b0));
         t = mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd2, 1'b0);
         t.wbw = 1'b1; t.wbrd = 5'd5; t.wbdata = 32'hDEAD;
         prog.push_back(t);
         t.wbrd = 5'd6; t.wbdata = 32'hBEEF;
         prog.push_back(t);
         prog.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1));
         prog.push_back(mk(5'd1, 5'd7, 1'b0, 1'b1, 5'd8, 1'b0));
         prog.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1));
         t = mk(5'd7, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0);
         t.flush_at = 4'd1;
         prog.push_back(t);
         prog.push_back(mk(5'd3, 5'd3, 1'b1, 1'b1, 5'd10, 1'b0));
         prog.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1));
         prog.push_back(mk(5'd7, 5'd1, 1'b0, 1'b1, 5'd11, 1'b0));
         for (int i = 0; i < 600; i++) prog.push_back(rand_instr());

         pres = 0;
         while (prog.size() > 0) begin
            t = prog[0];
            if (prog.size() <= 600) begin
               t.wbw = 1'($urandom); t.wbrd = 5'($urandom_range(0, 7)); t.wbdata = $urandom;
            end
            drive_cycle(t, pres == int'(t.flush_at), adv);
            if (adv) begin
               void'(prog.pop_front());
               pres = 0;
            end else begin
               pres++;
            end
         end
         t = '0; t.flush_at = 4'hF;
         repeat (2) drive_cycle(t, 1'b0, adv);
         @(posedge clk); #3;
         mon_en = 1'b0;

         // Reset arriving while a load-use stall is in progress
         @(negedge clk); #1;
         set_inputs(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1));
         @(negedge clk); #1;
         set_inputs(mk(5'd1, 5'd7, 1'b0, 1'b1, 5'd12, 1'b0));
         #1 check($sformatf("lat%0d_midrst_hazard", LAT), 160'(stallOut), 160'(1));
         @(negedge clk); #1;
         check($sformatf("lat%0d_midrst_stall2", LAT), 160'(stallOut), 160'(LAT > 1));
         resetIn = 1'b0;
         #1;
         check($sformatf("lat%0d_midrst_regs", LAT), 160'(act), 160'(0));
         check($sformatf("lat%0d_midrst_stall_in_rst", LAT), 160'(stallOut), 160'(0));
         @(negedge clk); #1;
         resetIn = 1'b1;
         #1 check($sformatf("lat%0d_midrst_no_residual", LAT), 160'(stallOut), 160'(0));
         @(posedge clk); #1;
         check($sformatf("lat%0d_midrst_latch", LAT), 160'({validOut, rs2Out, Data2Out}),
               160'({1'b1, 5'd7, rf[7]}));
         done = 1'b1;
      end
   end

   initial begin
      int cyc = 0;
      while (!(g_dut[0].done && g_dut[1].done) && cyc < 20000) begin
         @(posedge clk);
         cyc++;
      end
      if (!(g_dut[0].done && g_dut[1].done)) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got %0d cycles without completion, required completion", cyc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
